beep_sched: RTL and testbench



---
 rtl/beep_sched.sv | 218 +++++++++++++++++++++
 tb/tb_beep_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/beep_sched.sv
// Sound-effect scheduler for the snake game's buzzer: latches START/EAT/DIE
// requests, prioritises them and steps through a fixed note ROM per effect.
module beep_sched #(
  parameter int CLK_PRE   = 50_000_000,
  parameter int NOTE_TIME = 5_000_000,
  parameter int GAP_TIME  = 500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_start,
  input  logic        req_eat,
  input  logic        req_die,
  input  logic        mute,
  output logic        tone_en,
  output logic [17:0] tone_period,
  output logic [1:0]  effect_id,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [1:0] FX_NONE  = 2'd0;
  localparam logic [1:0] FX_START = 2'd1;
  localparam logic [1:0] FX_EAT   = 2'd2;
  localparam logic [1:0] FX_DIE   = 2'd3;

  // Note periods in clk cycles, truncated CLK_PRE / f_note.
  localparam logic [17:0] P_C4 = 18'(CLK_PRE / 262);
  localparam logic [17:0] P_E4 = 18'(CLK_PRE / 330);
  localparam logic [17:0] P_F4 = 18'(CLK_PRE / 349);
  localparam logic [17:0] P_G4 = 18'(CLK_PRE / 392);
  localparam logic [17:0] P_C5 = 18'(CLK_PRE / 523);
  localparam logic [17:0] P_G5 = 18'(CLK_PRE / 784);

  localparam logic [23:0] NOTE_LAST = 24'(NOTE_TIME - 1);
  localparam logic [23:0] GAP_LAST  = 24'(GAP_TIME - 1);

  function automatic logic [17:0] note_period(input logic [1:0] fx, input logic [1:0] idx);
    logic [17:0] p;
    p = 18'd0;
    case ({fx, idx})
      {FX_START, 2'd0}: p = P_C4;
      {FX_START, 2'd1}: p = P_E4;
      {FX_START, 2'd2}: p = P_G4;
      {FX_EAT,   2'd0}: p = P_C5;
      {FX_EAT,   2'd1}: p = P_G5;
      {FX_DIE,   2'd0}: p = P_G4;
      {FX_DIE,   2'd1}: p = P_F4;
      {FX_DIE,   2'd2}: p = P_E4;
      {FX_DIE,   2'd3}: p = P_C4;
      default:          p = 18'd0;
    endcase
    return p;
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] fx);
    logic [1:0] l;
    case (fx)
      FX_START: l = 2'd2;
      FX_EAT:   l = 2'd1;
      FX_DIE:   l = 2'd3;
      default:  l = 2'd0;
    endcase
    return l;
  endfunction

  state_t      state_q, state_d;
  logic        pend_start_q, pend_start_d;
  logic        pend_eat_q, pend_eat_d;
  logic        pend_die_q, pend_die_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] cnt_q, cnt_d;
  logic        tone_en_q, tone_en_d;
  logic [17:0] tone_period_q, tone_period_d;
  logic [1:0]  effect_id_q, effect_id_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  sel_fx;

  logic playing;
  logic drop_start, drop_eat, drop_die;
  logic preempt;

  // Requests are bare one-cycle pulses with no back-pressure; every high
  // sample lands in a sticky pending bit unless that effect is already playing.
  assign playing    = (state_q != ST_IDLE);
  assign drop_start = playing && (effect_id_q == FX_START);
  assign drop_eat   = playing && (effect_id_q == FX_EAT);
  assign drop_die   = playing && (effect_id_q == FX_DIE);
  assign preempt    = playing && req_die && (effect_id_q != FX_DIE);

  always_comb begin
    state_d       = state_q;
    pend_start_d  = pend_start_q | (req_start & ~drop_start);
    pend_eat_d    = pend_eat_q | (req_eat & ~drop_eat);
    pend_die_d    = pend_die_q | (req_die & ~drop_die);
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    tone_en_d     = tone_en_q;
    tone_period_d = tone_period_q;
    effect_id_d   = effect_id_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    sel_fx        = FX_NONE;

    case (state_q)
      ST_IDLE: begin
        // Clearing a bit still honours a request sampled on the same edge.
        if (pend_die_q) begin
          sel_fx     = FX_DIE;
          pend_die_d = req_die;
        end else if (pend_start_q) begin
          sel_fx       = FX_START;
          pend_start_d = req_start;
        end else if (pend_eat_q) begin
          sel_fx     = FX_EAT;
          pend_eat_d = req_eat;
        end
        if (sel_fx != FX_NONE) begin
          state_d       = ST_PLAY;
          idx_d         = 2'd0;
          cnt_d         = 24'd0;
          tone_period_d = note_period(sel_fx, 2'd0);
          effect_id_d   = sel_fx;
          busy_d        = 1'b1;
          tone_en_d     = ~mute;
        end
      end
      ST_PLAY: begin
        tone_en_d = ~mute;
        if (cnt_q == NOTE_LAST) begin
          state_d   = ST_GAP;
          cnt_d     = 24'd0;
          tone_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      ST_GAP: begin
        tone_en_d = 1'b0;
        if (cnt_q == GAP_LAST) begin
          cnt_d = 24'd0;
          if (idx_q == last_idx(effect_id_q)) begin
            state_d       = ST_IDLE;
            idx_d         = 2'd0;
            tone_period_d = 18'd0;
            effect_id_d   = FX_NONE;
            busy_d        = 1'b0;
            done_d        = 1'b1;
          end else begin
            state_d       = ST_PLAY;
            idx_d         = idx_q + 2'd1;
            tone_period_d = note_period(effect_id_q, idx_q + 2'd1);
            tone_en_d     = ~mute;
          end
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Game over: DIE cuts in immediately and flushes queued START/EAT.
    if (preempt) begin
      state_d       = ST_PLAY;
      idx_d         = 2'd0;
      cnt_d         = 24'd0;
      tone_period_d = note_period(FX_DIE, 2'd0);
      effect_id_d   = FX_DIE;
      busy_d        = 1'b1;
      tone_en_d     = ~mute;
      done_d        = 1'b0;
      pend_start_d  = req_start & ~drop_start;
      pend_eat_d    = req_eat & ~drop_eat;
      pend_die_d    = pend_die_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pend_start_q  <= 1'b0;
      pend_eat_q    <= 1'b0;
      pend_die_q    <= 1'b0;
      idx_q         <= 2'd0;
      cnt_q         <= 24'd0;
      tone_en_q     <= 1'b0;
      tone_period_q <= 18'd0;
      effect_id_q   <= FX_NONE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_start_q  <= pend_start_d;
      pend_eat_q    <= pend_eat_d;
      pend_die_q    <= pend_die_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      tone_en_q     <= tone_en_d;
      tone_period_q <= tone_period_d;
      effect_id_q   <= effect_id_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign tone_en     = tone_en_q;
  assign tone_period = tone_period_q;
  assign effect_id   = effect_id_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_beep_sched.sv
// Directed bench for beep_sched with NOTE_TIME=10, GAP_TIME=2; outputs are
// compared as one packed vector per cycle against a small effect-timeline model.
module tb_beep_sched;

  logic        clk;
  logic        rst;
  logic        req_start;
  logic        req_eat;
  logic        req_die;
  logic        mute;
  logic        tone_en;
  logic [17:0] tone_period;
  logic [1:0]  effect_id;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  int start_tab [3] = '{190839, 151515, 127551};
  int eat_tab   [2] = '{95602, 63775};
  int die_tab   [4] = '{127551, 143266, 151515, 190839};

  logic [22:0] obs;
  logic [22:0] exp_v;
  assign obs = {tone_en, tone_period, effect_id, busy, done};

  beep_sched #(
    .CLK_PRE  (50_000_000),
    .NOTE_TIME(10),
    .GAP_TIME (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_start  (req_start),
    .req_eat    (req_eat),
    .req_die    (req_die),
    .mute       (mute),
    .tone_en    (tone_en),
    .tone_period(tone_period),
    .effect_id  (effect_id),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {tone_en, tone_period, effect_id, busy, done} at cycle t after
  // the effect's first PLAY edge; t == notes*12 is the done cycle.
  function automatic logic [22:0] fx_vec(input int id, input int t, input logic m);
    int n;
    int note;
    logic en;
    logic [17:0] per;
    n = (id == 1) ? 3 : (id == 2) ? 2 : 4;
    if (t >= n * 12) return {1'b0, 18'd0, 2'd0, 1'b0, (t == n * 12)};
    note = t / 12;
    en = ((t % 12) < 10) && !m;
    case (id)
      1:       per = 18'(start_tab[note]);
      2:       per = 18'(eat_tab[note]);
      default: per = 18'(die_tab[note]);
    endcase
    return {en, per, 2'(id), 1'b1, 1'b0};
  endfunction

  task automatic pulse(input logic s, input logic e, input logic d);
    @(negedge clk);
    req_start = s;
    req_eat   = e;
    req_die   = d;
    @(negedge clk);
    req_start = 1'b0;
    req_eat   = 1'b0;
    req_die   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_start = 1'b1;
      req_eat   = 1'b1;
      req_die   = 1'b1;
    end
    @(negedge clk);
    req_start = 1'b0;
    req_eat   = 1'b0;
    req_die   = 1'b0;
    rst       = 1'b0;
    checks++;
    if ({dut.pend_start_q, dut.pend_eat_q, dut.pend_die_q} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pend got=%b exp=000", {dut.pend_start_q, dut.pend_eat_q, dut.pend_die_q});
    end
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      checks++;
      if (obs !== 23'd0) begin
        errors++;
        $display("FAIL reset_idle t=%0d got=%h exp=%h", t, obs, 23'd0);
      end
    end
  endtask

  task automatic test_single_eat;
    pulse(1'b0, 1'b1, 1'b0);
    for (int t = 0; t <= 30; t++) begin
      @(negedge clk);
      exp_v = fx_vec(2, t, 1'b0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL single_eat t=%0d got=%h exp=%h", t, obs, exp_v);
      end
    end
  endtask

  task automatic test_simultaneous;
    pulse(1'b1, 1'b1, 1'b0);
    for (int t = 0; t <= 36; t++) begin
      @(negedge clk);
      exp_v = fx_vec(1, t, 1'b0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL simul_start t=%0d got=%h exp=%h", t, obs, exp_v);
      end
    end
    for (int t = 0; t <= 28; t++) begin
      @(negedge clk);
      exp_v = fx_vec(2, t, 1'b0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL simul_eat t=%0d got=%h exp=%h", t, obs, exp_v);
      end
    end
  endtask

  task automatic test_keep_on_clear;
    // req_eat high on two edges: the second lands as the pending bit clears.
    @(negedge clk);
    req_eat = 1'b1;
    @(negedge clk);
    for (int t = 0; t <= 24; t++) begin
      @(negedge clk);
      req_eat = 1'b0;
      exp_v = fx_vec(2, t, 1'b0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL keep_first t=%0d got=%h exp=%h", t, obs, exp_v);
      end
    end
    for (int t = 0; t <= 28; t++) begin
      @(negedge clk);
      exp_v = fx_vec(2, t, 1'b0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL keep_second t=%0d got=%h exp=%h", t, obs, exp_v);
      end
    end
  endtask

  task automatic test_die_preempt;
    pulse(1'b0, 1'b1, 1'b0);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      req_start = (t == 1);
      req_die   = (t == 4);
      exp_v = fx_vec(2, t, 1'b0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL preempt_eat t=%0d got=%h exp=%h", t, obs, exp_v);
      end
    end
    for (int t = 0; t <= 54; t++) begin
      @(negedge clk);
      req_die = 1'b0;
      exp_v = fx_vec(3, t, 1'b0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL preempt_die t=%0d got=%h exp=%h", t, obs, exp_v);
      end
    end
  endtask

  task automatic test_mute_die;
    mute = 1'b1;
    pulse(1'b0, 1'b0, 1'b1);
    for (int t = 0; t <= 52; t++) begin
      @(negedge clk);
      exp_v = fx_vec(3, t, 1'b1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL mute_die t=%0d got=%h exp=%h", t, obs, exp_v);
      end
    end
    mute = 1'b0;
  endtask

  task automatic test_eat_retrigger;
    pulse(1'b0, 1'b1, 1'b0);
    for (int t = 0; t <= 50; t++) begin
      @(negedge clk);
      req_eat = (t == 14);
      exp_v = fx_vec(2, t, 1'b0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL eat_retrig t=%0d got=%h exp=%h", t, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_abort;
    pulse(1'b0, 1'b1, 1'b0);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      exp_v = fx_vec(2, t, 1'b0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL abort_eat t=%0d got=%h exp=%h", t, obs, exp_v);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 30; t++) begin
      checks++;
      if (obs !== 23'd0) begin
        errors++;
        $display("FAIL abort_idle t=%0d got=%h exp=%h", t, obs, 23'd0);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_start = 1'b0;
    req_eat   = 1'b0;
    req_die   = 1'b0;
    mute      = 1'b0;
    test_reset;
    test_single_eat;
    test_simultaneous;
    test_keep_on_clear;
    test_die_preempt;
    test_mute_die;
    test_eat_retrigger;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
